instruction_encoder: RTL and testbench

- Inverse of the core's immediate decode path: packs opcode, register, funct and immediate fields into a 32-bit RV32I instruction word.
- Feeds self-test instruction injection and the trace/patch unit.
- Two-stage valid/ready pipeline:
  - Stage A: capture and range check.
  - Stage B: bit packing, output register.

---
 rtl/instruction_encoder_pkg.sv | 58 +++++
 rtl/instruction_encoder_if.sv | 44 ++++
 rtl/instruction_encoder_imm_packer.sv | 49 ++++
 rtl/instruction_encoder.sv | 126 ++++++++++++
 tb/tb_instruction_encoder.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_enc_pkg
// Description : Shared types and constants for the RV32I instruction encoder:
//               instruction format enum, common opcodes, the request record
//               and the immediate range helper.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_enc_pkg;

    // Instruction formats; encodings 6 and 7 are illegal.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // Frequently injected major opcodes.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // One encode request as captured by the first pipeline stage.
    // fmt is kept raw so illegal encodings survive until packing.
    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_req_t;

    // True when the decoder-form immediate fits the field of its format.
    // I/S/B carry a 12-bit signed field, U/J a 20-bit one; R and illegal
    // formats have no immediate to check.
    function automatic logic imm_in_range(input logic [2:0] fmt, input logic [31:0] imm);
        logic ok;
        ok = 1'b1;
        case (fmt)
            FMT_I, FMT_S, FMT_B: ok = (imm == {{20{imm[11]}}, imm[11:0]});
            FMT_U, FMT_J:        ok = (imm == {{12{imm[19]}}, imm[19:0]});
            default:             ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_encoder_if
// Description : Request/response bundle of the instruction encoder. The
//               master drives requests and consumes packed words; the slave
//               is the encoder itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_encoder_if #(
    parameter int CNT_W = 16
);
    // Request side
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       fmt_i;
    logic [6:0]       opcode_i;
    logic [4:0]       rd_i;
    logic [4:0]       rs1_i;
    logic [4:0]       rs2_i;
    logic [2:0]       funct3_i;
    logic [6:0]       funct7_i;
    logic [31:0]      imm_i;

    // Response side
    logic             valid_o;
    logic             ready_i;
    logic [31:0]      instruction_o;
    logic             error_o;
    logic [CNT_W-1:0] count_o;

    modport master (
        output valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i,
               funct3_i, funct7_i, imm_i, ready_i,
        input  ready_o, valid_o, instruction_o, error_o, count_o
    );

    modport slave (
        input  valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i,
               funct3_i, funct7_i, imm_i, ready_i,
        output ready_o, valid_o, instruction_o, error_o, count_o
    );

endinterface
`default_nettype wire

// File: rtl/instruction_encoder_imm_packer.sv
`default_nettype none
// ============================================================================
// Module      : imm_packer
// Description : Pure combinational RV32I field placement. Takes a request in
//               decoder representation (B/J immediates already halved, U
//               immediate right-justified) and returns the instruction word.
//               Illegal formats produce an all-zero word and a flag.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_packer
    import instr_enc_pkg::*;
(
    input  enc_req_t    req,
    output logic [31:0] instr,
    output logic        fmt_illegal
);

    // Only the low 20 immediate bits are ever placed; the upper bits matter
    // solely to the range check upstream.
    logic unused_imm_hi;
    assign unused_imm_hi = ^req.imm[31:20];

    // Field placement per format; fields a format lacks stay zero.
    always_comb begin
        instr       = 32'd0;
        fmt_illegal = 1'b0;
        case (req.fmt)
            FMT_R: instr = {req.funct7, req.rs2, req.rs1, req.funct3,
                            req.rd, req.opcode};
            FMT_I: instr = {req.imm[11:0], req.rs1, req.funct3,
                            req.rd, req.opcode};
            FMT_S: instr = {req.imm[11:5], req.rs2, req.rs1, req.funct3,
                            req.imm[4:0], req.opcode};
            // imm[11] is offset bit 12, imm[10] is offset bit 11
            FMT_B: instr = {req.imm[11], req.imm[9:4], req.rs2, req.rs1,
                            req.funct3, req.imm[3:0], req.imm[10], req.opcode};
            FMT_U: instr = {req.imm[19:0], req.rd, req.opcode};
            // imm[19] is offset bit 20, imm[10] is offset bit 11
            FMT_J: instr = {req.imm[19], req.imm[9:0], req.imm[10],
                            req.imm[18:11], req.rd, req.opcode};
            default: begin
                instr       = 32'd0;
                fmt_illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instruction_encoder
// Description : Two-stage valid/ready pipeline that packs opcode, register,
//               funct and immediate fields into a 32-bit RV32I word.
//               Stage A captures the request and checks the immediate range,
//               stage B packs the word and holds it for the consumer.
//               Optional macro IMM_RANGE_CHECK_EN: when defined, immediates
//               that do not fit their field raise error_o; otherwise they
//               are silently truncated and only illegal formats raise it.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_encoder
    import instr_enc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    instruction_encoder_if.slave bus
);

    enc_req_t         in_req;
    enc_req_t         a_req;
    logic             a_vld;
    logic             b_vld;
    logic [31:0]      b_instr;
    logic             b_err;
    logic [CNT_W-1:0] count;

    logic             in_acc;
    logic             out_acc;
    logic             b_free;
    logic             a_adv;
    logic [31:0]      packed_instr;
    logic             fmt_illegal;
    logic             b_err_d;

    // Gather the incoming request fields into one record.
    always_comb begin
        in_req        = '0;
        in_req.fmt    = bus.fmt_i;
        in_req.opcode = bus.opcode_i;
        in_req.rd     = bus.rd_i;
        in_req.rs1    = bus.rs1_i;
        in_req.rs2    = bus.rs2_i;
        in_req.funct3 = bus.funct3_i;
        in_req.funct7 = bus.funct7_i;
        in_req.imm    = bus.imm_i;
    end

    // Stage B can take a word when it is empty or its word leaves this cycle;
    // that makes a full pipeline with a consumer ready still accept input.
    assign out_acc     = b_vld & bus.ready_i;
    assign b_free      = ~b_vld | bus.ready_i;
    assign a_adv       = a_vld & b_free;
    assign bus.ready_o = ~a_vld | ~b_vld | bus.ready_i;
    assign in_acc      = bus.valid_i & bus.ready_o;

    // Stage A: take a new request, or drain once its contents move to B.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_vld <= 1'b0;
            a_req <= '0;
        end else if (in_acc) begin
            a_vld <= 1'b1;
            a_req <= in_req;
        end else if (a_adv) begin
            a_vld <= 1'b0;
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    logic a_range_err;

    // Range flag travels alongside the captured request in stage A.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_range_err <= 1'b0;
        end else if (in_acc) begin
            a_range_err <= ~imm_in_range(bus.fmt_i, bus.imm_i);
        end
    end

    assign b_err_d = fmt_illegal | a_range_err;
`else
    assign b_err_d = fmt_illegal;
`endif

    imm_packer u_imm_packer (
        .req         (a_req),
        .instr       (packed_instr),
        .fmt_illegal (fmt_illegal)
    );

    // Stage B: load the packed word from A; hold it while the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_vld   <= 1'b0;
            b_instr <= 32'd0;
            b_err   <= 1'b0;
        end else if (a_adv) begin
            b_vld   <= 1'b1;
            b_instr <= packed_instr;
            b_err   <= b_err_d;
        end else if (out_acc) begin
            b_vld   <= 1'b0;
        end
    end

    // Count handed-off words; wraps naturally at the counter width.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (out_acc) begin
            count <= count + 1'b1;
        end
    end

    assign bus.valid_o       = b_vld;
    assign bus.instruction_o = b_instr;
    assign bus.error_o       = b_err;
    assign bus.count_o       = count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_encoder
// Description : Self-checking bench for instruction_encoder: directed
//               vectors, randomized stream with random backpressure,
//               B/J round-trip decode, stall and mid-stream reset.
//               Follows IMM_RANGE_CHECK_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_encoder;
    import instr_enc_pkg::*;

    localparam int TB_CNT_W = 4;
`ifdef IMM_RANGE_CHECK_EN
    localparam bit RANGE_ON = 1'b1;
`else
    localparam bit RANGE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    instruction_encoder_if #(.CNT_W(TB_CNT_W)) bus ();

    instruction_encoder #(.CNT_W(TB_CNT_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        err;
        bit          roundtrip;
        logic [2:0]  fmt;
        logic [31:0] imm;
    } exp_t;

    exp_t sb[$];
    int   exp_count = 0;
    bit   rand_ready = 1'b0;

    // ---------------- reference model (ISA-level view) ----------------
    function automatic bit in_range(input logic [2:0] fmt, input logic [31:0] imm);
        int v;
        v = imm;
        if (fmt >= 3'd1 && fmt <= 3'd3) return (v >= -2048 && v <= 2047);
        if (fmt == 3'd4 || fmt == 3'd5) return (v >= -524288 && v <= 524287);
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_word(input enc_req_t r);
        bit [31:0] w, off, base;
        base = 32'(r.opcode) | (32'(r.funct3) << 12) | (32'(r.rs1) << 15);
        off  = r.imm << 1;
        w    = 32'd0;
        case (int'(r.fmt))
            0: w = base | (32'(r.rd) << 7) | (32'(r.rs2) << 20) | (32'(r.funct7) << 25);
            1: w = base | (32'(r.rd) << 7) | ((r.imm & 32'hFFF) << 20);
            2: w = base | ((r.imm & 32'h1F) << 7) | (32'(r.rs2) << 20)
                        | (((r.imm >> 5) & 32'h7F) << 25);
            3: w = base | (32'(r.rs2) << 20) | (((off >> 12) & 32'h1) << 31)
                        | (((off >> 5) & 32'h3F) << 25) | (((off >> 1) & 32'hF) << 8)
                        | (((off >> 11) & 32'h1) << 7);
            4: w = 32'(r.opcode) | (32'(r.rd) << 7) | ((r.imm & 32'hFFFFF) << 12);
            5: w = 32'(r.opcode) | (32'(r.rd) << 7) | (((off >> 20) & 32'h1) << 31)
                        | (((off >> 1) & 32'h3FF) << 21) | (((off >> 11) & 32'h1) << 20)
                        | (((off >> 12) & 32'hFF) << 12);
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic exp_t make_exp(input enc_req_t r);
        exp_t e;
        bit   ok;
        ok          = in_range(r.fmt, r.imm);
        e.instr     = model_word(r);
        e.err       = (r.fmt > 3'd5) ? 1'b1 : (RANGE_ON && !ok);
        e.roundtrip = (r.fmt == 3'd3 || r.fmt == 3'd5) && ok;
        e.fmt       = r.fmt;
        e.imm       = r.imm;
        return e;
    endfunction

    // Core-style immediate decode back to decoder representation.
    function automatic logic [31:0] decode_imm(input logic [2:0] fmt, input logic [31:0] w);
        logic [12:0]        ob;
        logic [20:0]        oj;
        logic signed [31:0] s;
        if (fmt == 3'd3) begin
            ob = {w[31], w[7], w[30:25], w[11:8], 1'b0};
            s  = {{19{ob[12]}}, ob};
        end else begin
            oj = {w[31], w[19:12], w[20], w[30:21], 1'b0};
            s  = {{11{oj[20]}}, oj};
        end
        return s >>> 1;
    endfunction

    function automatic enc_req_t cur_req();
        enc_req_t r;
        r.fmt = bus.fmt_i;       r.opcode = bus.opcode_i; r.rd = bus.rd_i;
        r.rs1 = bus.rs1_i;       r.rs2 = bus.rs2_i;       r.funct3 = bus.funct3_i;
        r.funct7 = bus.funct7_i; r.imm = bus.imm_i;
        return r;
    endfunction

    function automatic enc_req_t make_req(input int fmt, input logic [6:0] opc, input int rd,
                                          input int rs1, input int rs2, input int f3,
                                          input logic [31:0] imm);
        enc_req_t r;
        r.fmt = 3'(fmt); r.opcode = opc; r.rd = 5'(rd); r.rs1 = 5'(rs1);
        r.rs2 = 5'(rs2); r.funct3 = 3'(f3); r.funct7 = 7'd0; r.imm = imm;
        return r;
    endfunction

    function automatic enc_req_t rand_req(input int fmt, input bit legal);
        enc_req_t    r;
        logic [31:0] raw;
        raw = $urandom;
        r.fmt = 3'(fmt);
        r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
        r.funct3 = 3'($urandom); r.funct7 = 7'($urandom);
        case (fmt)
            0: r.opcode = 7'b0110011;
            1: r.opcode = raw[31] ? OPC_LOAD : OPC_OPIMM;
            2: r.opcode = OPC_STORE;
            3: r.opcode = OPC_BRANCH;
            4: r.opcode = raw[31] ? OPC_LUI : OPC_AUIPC;
            5: r.opcode = OPC_JAL;
            default: r.opcode = 7'($urandom);
        endcase
        if (!legal)                     r.imm = $urandom;
        else if (fmt == 4 || fmt == 5)  r.imm = {{12{raw[19]}}, raw[19:0]};
        else                            r.imm = {{20{raw[11]}}, raw[11:0]};
        return r;
    endfunction

    // ---------------- scoreboard monitor (samples on falling edge) ----------------
    always @(negedge clk) begin : monitor
        logic [31:0] dec;
        if (!rst_ni) begin
            sb.delete();
            exp_count = 0;
        end else begin
            if (bus.valid_o) begin
                if (sb.size() == 0) begin
                    check_value("spurious_valid_o", 32'(bus.valid_o), 32'd0);
                end else begin
                    check_value("instr", bus.instruction_o, sb[0].instr);
                    check_value("error", 32'(bus.error_o), 32'(sb[0].err));
                    if (bus.ready_i) begin
                        if (sb[0].roundtrip) begin
                            dec = decode_imm(sb[0].fmt, bus.instruction_o);
                            check_value("roundtrip", dec, sb[0].imm);
                        end
                        check_value("count_o", 32'(bus.count_o), 32'(exp_count));
                        void'(sb.pop_front());
                        exp_count = (exp_count + 1) % (1 << TB_CNT_W);
                    end
                end
            end
            if (bus.valid_i && bus.ready_o) sb.push_back(make_exp(cur_req()));
        end
    end

    // Random consumer backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.ready_i = ($urandom_range(0, 3) != 0);
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input enc_req_t r);
        bus.valid_i = 1'b1;     bus.fmt_i = r.fmt;       bus.opcode_i = r.opcode;
        bus.rd_i = r.rd;        bus.rs1_i = r.rs1;       bus.rs2_i = r.rs2;
        bus.funct3_i = r.funct3; bus.funct7_i = r.funct7; bus.imm_i = r.imm;
    endtask

    task automatic send(input enc_req_t r);
        int t;
        t = 0;
        @(posedge clk); #1;
        drive_req(r);
        @(negedge clk);
        while (!bus.ready_o && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!bus.ready_o) check_value("send_timeout", 32'(bus.ready_o), 32'd1);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
    endtask

    // Send into an empty pipeline with the consumer ready and check the
    // two-cycle latency and the packed result.
    task automatic send_expect(input string tag, input enc_req_t r,
                               input logic [31:0] exp_instr, input logic exp_err);
        send(r);
        @(negedge clk);
        check_value({tag, "_lat1_valid"}, 32'(bus.valid_o), 32'd0);
        @(negedge clk);
        check_value({tag, "_lat2_valid"}, 32'(bus.valid_o), 32'd1);
        check_value({tag, "_instr"}, bus.instruction_o, exp_instr);
        check_value({tag, "_err"}, 32'(bus.error_o), 32'(exp_err));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || bus.valid_o) && t < 500) begin
            t++;
            @(negedge clk);
        end
        check_value("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        enc_req_t reqs[4];
        int       idx;
        int       acc;
        int       fmt;

        rst_ni = 1'b0;
        bus.valid_i = 1'b0; bus.ready_i = 1'b1;
        bus.fmt_i = '0; bus.opcode_i = '0; bus.rd_i = '0; bus.rs1_i = '0;
        bus.rs2_i = '0; bus.funct3_i = '0; bus.funct7_i = '0; bus.imm_i = '0;

        repeat (3) @(negedge clk);
        check_value("rst_valid_o", 32'(bus.valid_o), 32'd0);
        check_value("rst_instr", bus.instruction_o, 32'd0);
        check_value("rst_error", 32'(bus.error_o), 32'd0);
        check_value("rst_count", 32'(bus.count_o), 32'd0);
        check_value("rst_ready_o", 32'(bus.ready_o), 32'd1);
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // Directed vectors
        send_expect("dir_i", make_req(1, OPC_OPIMM, 5, 6, 0, 0, 32'hFFFF_FFFF), 32'hFFF3_0293, 1'b0);
        send_expect("dir_s", make_req(2, OPC_STORE, 0, 2, 8, 2, 32'h0000_0014), 32'h0081_2A23, 1'b0);
        send_expect("dir_range", make_req(1, OPC_OPIMM, 1, 2, 0, 0, 32'h0000_0800), 32'h8001_0093, RANGE_ON);
        send_expect("dir_illegal", make_req(6, OPC_OPIMM, 1, 2, 3, 0, 32'h0000_0001), 32'h0000_0000, 1'b1);
        send_expect("dir_u", make_req(4, OPC_LUI, 3, 0, 0, 0, 32'h0001_2345), 32'h1234_51B7, 1'b0);

        // Randomized stream: B and J round trips, then mixed formats
        rand_ready = 1'b1;
        for (int i = 0; i < 2600; i++) begin
            if (i < 1000)      fmt = 3;
            else if (i < 2000) fmt = 5;
            else               fmt = $urandom_range(0, 7);
            send(rand_req(fmt, (i < 2000) || ($urandom_range(0, 4) != 0)));
        end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        bus.ready_i = 1'b1;
        wait_drain();

        // Backpressure: consumer stalled 5 cycles, 4 requests offered
        pulse_reset();
        check_value("bp_count_start", 32'(bus.count_o), 32'd0);
        for (int i = 0; i < 4; i++) reqs[i] = rand_req($urandom_range(0, 5), 1'b1);
        bus.ready_i = 1'b0;
        idx = 0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            drive_req(reqs[idx]);
            @(negedge clk);
            if (bus.valid_i && bus.ready_o) begin
                idx++;
                acc++;
            end
        end
        check_value("bp_accepted", 32'(acc), 32'd2);
        check_value("bp_ready_low", 32'(bus.ready_o), 32'd0);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        while (idx < 4) begin
            send(reqs[idx]);
            idx++;
        end
        wait_drain();
        check_value("bp_count_end", 32'(bus.count_o), 32'd4);

        // Reset with both stages full
        bus.ready_i = 1'b0;
        send(rand_req(1, 1'b1));
        send(rand_req(2, 1'b1));
        @(negedge clk);
        check_value("mid_full_valid", 32'(bus.valid_o), 32'd1);
        check_value("mid_ready_low", 32'(bus.ready_o), 32'd0);
        @(posedge clk); #2;
        rst_ni = 1'b0;
        #1;
        check_value("mid_rst_valid", 32'(bus.valid_o), 32'd0);
        check_value("mid_rst_count", 32'(bus.count_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        bus.ready_i = 1'b1;
        repeat (10) @(negedge clk);
        check_value("mid_post_valid", 32'(bus.valid_o), 32'd0);
        check_value("mid_post_count", 32'(bus.count_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
